round_sequencer: RTL

//  Turn-level controller for the two-player fight datapath. Collects per-player move commits,

---
 rtl/round_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/round_sequencer.sv
// Turn-level controller for the two-player fight: gathers commits, strobes actionEnable, scores health.
// Optional `define SUDDEN_DEATH_EN keeps playing past the turn limit while health is tied.
module round_sequencer #(
  parameter int MAX_TURNS   = 30,
  parameter int TURN_W      = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int SETTLE_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              commit1,
  input  logic              commit2,
  input  logic [1:0]        health1,
  input  logic [1:0]        health2,
  output logic              actionEnable,
  output logic              isGameOver,
  output logic              player_reset,
  output logic              force_await1,
  output logic              force_await2,
  output logic [1:0]        winner,
  output logic [TURN_W-1:0] turn_count
);

  typedef enum logic [2:0] {IDLE, CLR, ARM, FIRE, SETTLE, CHECK, OVER} state_t;

  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              action_n, over_n, preset_n, fa1_n, fa2_n;
  logic [1:0]        winner_n;
  logic [TURN_W-1:0] turn_n, turn_inc;
  logic              h1_zero, h2_zero, at_limit;

  assign turn_inc = (&turn_count) ? turn_count : turn_count + 1'b1;
  assign h1_zero  = (health1 == 2'd0);
  assign h2_zero  = (health2 == 2'd0);
`ifdef SUDDEN_DEATH_EN
  assign at_limit = (turn_inc >= TURN_W'(MAX_TURNS));
`else
  assign at_limit = (turn_inc == TURN_W'(MAX_TURNS));
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      actionEnable <= 1'b0;
      isGameOver   <= 1'b0;
      player_reset <= 1'b1;
      force_await1 <= 1'b0;
      force_await2 <= 1'b0;
      winner       <= 2'b00;
      turn_count   <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      actionEnable <= action_n;
      isGameOver   <= over_n;
      player_reset <= preset_n;
      force_await1 <= fa1_n;
      force_await2 <= fa2_n;
      winner       <= winner_n;
      turn_count   <= turn_n;
    end
  end

  // Outputs are computed for the state being entered, so each register reflects the current state.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    action_n = 1'b0;
    over_n   = 1'b0;
    preset_n = 1'b1;
    fa1_n    = force_await1;
    fa2_n    = force_await2;
    winner_n = winner;
    turn_n   = turn_count;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = CLR;
          preset_n = 1'b0;
          turn_n   = '0;
          winner_n = 2'b00;
        end
      end
      CLR: begin
        state_n = ARM;
        cnt_n   = '0;
        fa1_n   = 1'b0;
        fa2_n   = 1'b0;
      end
      ARM: begin
        if (commit1 && commit2) begin
          state_n  = FIRE;
          action_n = 1'b1;
          fa1_n    = 1'b0;
          fa2_n    = 1'b0;
          cnt_n    = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_n  = FIRE;
          action_n = 1'b1;
          fa1_n    = ~commit1;
          fa2_n    = ~commit2;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      FIRE: begin
        state_n = SETTLE;
        fa1_n   = 1'b0;
        fa2_n   = 1'b0;
        cnt_n   = '0;
      end
      SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          state_n = CHECK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CHECK: begin
        turn_n  = turn_inc;
        state_n = ARM;
        cnt_n   = '0;
        // A knockout outranks the turn limit; {h1_zero,h2_zero} maps directly onto the winner code.
        if (h1_zero || h2_zero) begin
          state_n  = OVER;
          over_n   = 1'b1;
          winner_n = {h1_zero, h2_zero};
        end else if (at_limit) begin
          if (health1 > health2) begin
            state_n  = OVER;
            over_n   = 1'b1;
            winner_n = 2'b01;
          end else if (health1 < health2) begin
            state_n  = OVER;
            over_n   = 1'b1;
            winner_n = 2'b10;
          end else begin
`ifdef SUDDEN_DEATH_EN
            state_n = ARM;
`else
            state_n  = OVER;
            over_n   = 1'b1;
            winner_n = 2'b11;
`endif
          end
        end
      end
      OVER: begin
        over_n = 1'b1;
        if (start) begin
          state_n  = CLR;
          over_n   = 1'b0;
          preset_n = 1'b0;
          turn_n   = '0;
          winner_n = 2'b00;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
